// File: rtl/mem_trace_recorder.sv
// mem_trace_recorder: captures warp-wide memory-trace requests, stamps them
// with a free-running cycle counter, buffers them in a small FIFO and emits
// one lane record per handshake, lowest active lane first.
// Optional build macro: MEM_TRACE_REC_STATS_EN adds saturating load/store
// record counters; without it stat_loads/stat_stores are constant zero.
module mem_trace_recorder #(
  parameter int NUM_LANES  = 4,
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int MASK_WIDTH = 8
) (
  input  logic                             clock,
  input  logic                             reset_n,
  output logic                             req_ready,
  input  logic [NUM_LANES-1:0]             req_valid,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]  req_address,
  input  logic [NUM_LANES-1:0]             req_is_store,
  input  logic [MASK_WIDTH*NUM_LANES-1:0]  req_store_mask,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]  req_data,
  input  logic                             req_finished,
  output logic                             rec_valid,
  input  logic                             rec_ready,
  output logic [63:0]                      rec_cycle,
  output logic [4:0]                       rec_tid,
  output logic [DATA_WIDTH-1:0]            rec_address,
  output logic                             rec_is_store,
  output logic [MASK_WIDTH-1:0]            rec_store_mask,
  output logic [DATA_WIDTH-1:0]            rec_data,
  output logic                             rec_last,
  output logic                             rec_done,
  output logic [31:0]                      stat_loads,
  output logic [31:0]                      stat_stores
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  // Warp storage. The head entry is read combinationally so a warp captured
  // at one edge is presented as a record right after that edge.
  logic [63:0]                     cycle_mem [DEPTH];
  logic [NUM_LANES-1:0]            valid_mem [DEPTH];
  logic [NUM_LANES-1:0]            store_mem [DEPTH];
  logic [DATA_WIDTH*NUM_LANES-1:0] addr_mem  [DEPTH];
  logic [MASK_WIDTH*NUM_LANES-1:0] mask_mem  [DEPTH];
  logic [DATA_WIDTH*NUM_LANES-1:0] data_mem  [DEPTH];

  logic [AW-1:0]        wr_ptr_reg;
  logic [AW-1:0]        rd_ptr_reg;
  logic [CW-1:0]        count_reg;
  logic [CW-1:0]        count_next;
  logic [63:0]          cycle_reg;
  logic [NUM_LANES-1:0] served_reg;   // lanes of the head entry already emitted
  logic                 finished_reg;
  logic                 done_reg;
  logic                 done_next;

  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 fire;
  logic                 pop;
  logic [NUM_LANES-1:0] remaining;
  logic [NUM_LANES-1:0] lane_onehot;
  logic [LW-1:0]        lane_sel;
  logic                 last_raw;

  logic [DATA_WIDTH*NUM_LANES-1:0] head_addr_word;
  logic [MASK_WIDTH*NUM_LANES-1:0] head_mask_word;
  logic [DATA_WIDTH*NUM_LANES-1:0] head_data_word;
  logic [NUM_LANES-1:0]            head_store_word;
  logic [DATA_WIDTH-1:0]           head_addr [NUM_LANES];
  logic [MASK_WIDTH-1:0]           head_mask [NUM_LANES];
  logic [DATA_WIDTH-1:0]           head_data [NUM_LANES];

  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  assign req_ready = !full;
  assign push      = !full && (|req_valid);

  assign remaining   = valid_mem[rd_ptr_reg] & ~served_reg;
  assign lane_onehot = remaining & (~remaining + NUM_LANES'(1));
  assign last_raw    = ((remaining & (remaining - NUM_LANES'(1))) == '0);

  assign fire = !empty && rec_ready;
  assign pop  = fire && last_raw;

  assign head_addr_word  = addr_mem[rd_ptr_reg];
  assign head_mask_word  = mask_mem[rd_ptr_reg];
  assign head_data_word  = data_mem[rd_ptr_reg];
  assign head_store_word = store_mem[rd_ptr_reg];

  // Split the packed head words into per-lane fields.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign head_addr[gi] = head_addr_word[DATA_WIDTH*gi +: DATA_WIDTH];
      assign head_mask[gi] = head_mask_word[MASK_WIDTH*gi +: MASK_WIDTH];
      assign head_data[gi] = head_data_word[DATA_WIDTH*gi +: DATA_WIDTH];
    end
  endgenerate

  // Current lane = lowest lane still pending in the head entry.
  always_comb begin
    lane_sel = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (remaining[i]) lane_sel = LW'(i);
    end
  end

  // Record outputs are forced to zero while nothing is buffered, so stale
  // storage contents never leak out after reset.
  assign rec_valid      = !empty;
  assign rec_cycle      = empty ? '0 : cycle_mem[rd_ptr_reg];
  assign rec_tid        = empty ? '0 : 5'(lane_sel);
  assign rec_address    = empty ? '0 : head_addr[lane_sel];
  assign rec_is_store   = !empty && head_store_word[lane_sel];
  assign rec_store_mask = empty ? '0 : head_mask[lane_sel];
  assign rec_data       = empty ? '0 : head_data[lane_sel];
  assign rec_last       = !empty && last_raw;
  assign rec_done       = done_reg;

  // Occupancy after this edge; a simultaneous push and pop cancel out.
  always_comb begin
    count_next = count_reg;
    if (push && !pop) count_next = count_reg + CW'(1);
    else if (!push && pop) count_next = count_reg - CW'(1);
  end

  assign done_next = (finished_reg || req_finished) && (count_next == '0);

  // Warp payload write; storage itself needs no reset, validity lives in count_reg.
  always_ff @(posedge clock) begin
    if (push) begin
      cycle_mem[wr_ptr_reg] <= cycle_reg;
      valid_mem[wr_ptr_reg] <= req_valid;
      store_mem[wr_ptr_reg] <= req_is_store;
      addr_mem[wr_ptr_reg]  <= req_address;
      mask_mem[wr_ptr_reg]  <= req_store_mask;
      data_mem[wr_ptr_reg]  <= req_data;
    end
  end

  // FIFO control, serializer progress, cycle counter and finished tracking.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      cycle_reg    <= '0;
      served_reg   <= '0;
      finished_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      cycle_reg    <= cycle_reg + 64'd1;
      count_reg    <= count_next;
      finished_reg <= finished_reg || req_finished;
      done_reg     <= done_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
        served_reg <= '0;
      end else if (fire) begin
        served_reg <= served_reg | lane_onehot;
      end
    end
  end

`ifdef MEM_TRACE_REC_STATS_EN
  logic [31:0] loads_reg;
  logic [31:0] stores_reg;

  // Saturating counts of accepted records, split by access type.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      loads_reg  <= '0;
      stores_reg <= '0;
    end else if (fire) begin
      if (rec_is_store) begin
        if (stores_reg != 32'hFFFF_FFFF) stores_reg <= stores_reg + 32'd1;
      end else begin
        if (loads_reg != 32'hFFFF_FFFF) loads_reg <= loads_reg + 32'd1;
      end
    end
  end

  assign stat_loads  = loads_reg;
  assign stat_stores = stores_reg;
`else
  assign stat_loads  = '0;
  assign stat_stores = '0;
`endif

endmodule

// File: tb/tb_mem_trace_recorder.sv
// Randomized scoreboard bench for mem_trace_recorder. The driver expands each
// accepted warp into its expected lane records; a negedge monitor compares
// and retires them on every handshake.
module tb_mem_trace_recorder;
  localparam int NL    = 4;
  localparam int DEPTH = 4;
  localparam int DW    = 64;
  localparam int MW    = 8;

  typedef struct {
    logic [63:0] cyc;
    logic [4:0]  tid;
    logic [63:0] addr;
    logic        st;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        last;
  } rec_t;

  logic              clock;
  logic              reset_n;
  logic              req_ready;
  logic [NL-1:0]     req_valid;
  logic [DW*NL-1:0]  req_address;
  logic [NL-1:0]     req_is_store;
  logic [MW*NL-1:0]  req_store_mask;
  logic [DW*NL-1:0]  req_data;
  logic              req_finished;
  logic              rec_valid;
  logic              rec_ready;
  logic [63:0]       rec_cycle;
  logic [4:0]        rec_tid;
  logic [DW-1:0]     rec_address;
  logic              rec_is_store;
  logic [MW-1:0]     rec_store_mask;
  logic [DW-1:0]     rec_data;
  logic              rec_last;
  logic              rec_done;
  logic [31:0]       stat_loads;
  logic [31:0]       stat_stores;

  rec_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          pushed = 0;      // warps captured (model)
  int          popped = 0;      // warps fully consumed (model)
  bit          fin_seen = 0;
  int unsigned exp_loads = 0;
  int unsigned exp_stores = 0;
  longint unsigned cyc = 0;

  mem_trace_recorder #(.NUM_LANES(NL), .DEPTH(DEPTH), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) dut (
    .clock(clock), .reset_n(reset_n), .req_ready(req_ready), .req_valid(req_valid),
    .req_address(req_address), .req_is_store(req_is_store), .req_store_mask(req_store_mask),
    .req_data(req_data), .req_finished(req_finished), .rec_valid(rec_valid),
    .rec_ready(rec_ready), .rec_cycle(rec_cycle), .rec_tid(rec_tid),
    .rec_address(rec_address), .rec_is_store(rec_is_store), .rec_store_mask(rec_store_mask),
    .rec_data(rec_data), .rec_last(rec_last), .rec_done(rec_done),
    .stat_loads(stat_loads), .stat_stores(stat_stores)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus; records of an accepted warp join the scoreboard
  // once the capture edge has passed.
  task automatic drive(input logic [NL-1:0] v, input logic rr, input logic fin, output bit acc);
    logic [DW*NL-1:0] a;
    logic [DW*NL-1:0] d;
    logic [MW*NL-1:0] m;
    logic [NL-1:0]    st;
    int               hi;
    rec_t             r;
    for (int i = 0; i < NL; i++) begin
      a[DW*i +: DW] = {$urandom, $urandom};
      d[DW*i +: DW] = {$urandom, $urandom};
      m[MW*i +: MW] = 8'($urandom);
    end
    st = NL'($urandom);
    req_valid = v; req_address = a; req_data = d; req_store_mask = m;
    req_is_store = st; rec_ready = rr; req_finished = fin;
    acc = (v != '0) && ((pushed - popped) < DEPTH);
    @(posedge clock); #1;
    if (acc) begin
      pushed++;
      hi = 0;
      for (int i = 0; i < NL; i++) if (v[i]) hi = i;
      for (int i = 0; i < NL; i++) begin
        if (v[i]) begin
          r.cyc = 64'(cyc); r.tid = 5'(i); r.addr = a[DW*i +: DW]; r.st = st[i];
          r.mask = m[MW*i +: MW]; r.data = d[DW*i +: DW]; r.last = (i == hi);
          exp_q.push_back(r);
        end
      end
    end
    if (fin) fin_seen = 1;
    cyc++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_valid = '0; rec_ready = 1'b0; req_finished = 1'b0;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rec_valid", 64'(rec_valid), 64'd0);
    check("rst_rec_last", 64'(rec_last), 64'd0);
    check("rst_rec_done", 64'(rec_done), 64'd0);
    check("rst_rec_cycle", rec_cycle, 64'd0);
    check("rst_rec_tid", 64'(rec_tid), 64'd0);
    check("rst_rec_address", rec_address, 64'd0);
    check("rst_rec_data", rec_data, 64'd0);
    check("rst_rec_mask", 64'(rec_store_mask), 64'd0);
    check("rst_stat_loads", 64'(stat_loads), 64'd0);
    check("rst_stat_stores", 64'(stat_stores), 64'd0);
    exp_q.delete();
    pushed = 0; popped = 0; fin_seen = 0; exp_loads = 0; exp_stores = 0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    cyc = 0;
  endtask

  // Monitor: sample mid-cycle, compare against the scoreboard head, retire on handshake.
  always @(negedge clock) begin
    if (reset_n) begin
      check("req_ready", 64'(req_ready), 64'((pushed - popped) < DEPTH));
      check("rec_valid", 64'(rec_valid), 64'(exp_q.size() != 0));
      check("rec_done", 64'(rec_done), 64'(fin_seen && exp_q.size() == 0));
`ifdef MEM_TRACE_REC_STATS_EN
      check("stat_loads", 64'(stat_loads), 64'(exp_loads));
      check("stat_stores", 64'(stat_stores), 64'(exp_stores));
`else
      check("stat_loads", 64'(stat_loads), 64'd0);
      check("stat_stores", 64'(stat_stores), 64'd0);
`endif
      if (exp_q.size() != 0) begin
        check("rec_cycle", rec_cycle, exp_q[0].cyc);
        check("rec_tid", 64'(rec_tid), 64'(exp_q[0].tid));
        check("rec_address", rec_address, exp_q[0].addr);
        check("rec_is_store", 64'(rec_is_store), 64'(exp_q[0].st));
        check("rec_store_mask", 64'(rec_store_mask), 64'(exp_q[0].mask));
        check("rec_data", rec_data, exp_q[0].data);
        check("rec_last", 64'(rec_last), 64'(exp_q[0].last));
        if (rec_ready) begin
          $display("rec cyc=%0d tid=%0d st=%0b last=%0b addr=%h", exp_q[0].cyc,
                   exp_q[0].tid, exp_q[0].st, exp_q[0].last, exp_q[0].addr);
          if (exp_q[0].st) exp_stores++;
          else exp_loads++;
          if (exp_q[0].last) popped++;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int k;
    logic [NL-1:0] v5;
    reset_n = 1'b1; req_valid = '0; req_address = '0; req_is_store = '0;
    req_store_mask = '0; req_data = '0; req_finished = 1'b0; rec_ready = 1'b0;
    #2;
    do_reset();

    // Idle until counter 5, then a two-lane warp (lanes 0 and 2).
    repeat (5) drive('0, 1'b1, 1'b0, acc);
    drive(4'b0101, 1'b1, 1'b0, acc);
    // No request lanes set: nothing must be captured.
    repeat (10) drive('0, 1'b1, 1'b0, acc);

    // Fill the FIFO with single-lane warps while the sink stalls.
    for (int i = 0; i < DEPTH; i++) drive(NL'(1) << (i % NL), 1'b0, 1'b0, acc);
    v5 = 4'b1000;
    drive(v5, 1'b0, 1'b0, acc);
    k = 0;
    do begin
      drive(v5, 1'b1, 1'b0, acc);
      k++;
    end while (!acc && k < 20);
    check("held_warp_accepted", 64'(acc), 64'd1);
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin drive('0, 1'b1, 1'b0, acc); k++; end

    // Full warp with a sink that alternates stall/accept.
    drive(4'b1111, 1'b0, 1'b0, acc);
    for (int i = 0; i < 10; i++) drive('0, 1'(i % 2), 1'b0, acc);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) == 0) ? NL'(0) : NL'($urandom),
            ($urandom_range(0, 3) != 0), 1'b0, acc);
    end
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin drive('0, 1'b1, 1'b0, acc); k++; end

    // Finish indication together with a final three-lane warp.
    drive(4'b0111, 1'b1, 1'b1, acc);
    repeat (5) drive('0, 1'b1, 1'b0, acc);

    // Reset in the middle of serializing a warp.
    drive(4'b1111, 1'b0, 1'b0, acc);
    drive('0, 1'b1, 1'b0, acc);
    do_reset();
    repeat (5) drive('0, 1'b1, 1'b0, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
